// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds the divider state encoding, the bypass threshold and the
// phase-length split used by every divider instance.
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HIGH   = 2'd1,
      LOW    = 2'd2,
      BYPASS = 2'd3
   } div_state_e;

   // Ratios at or below this value select the gated bypass path
   localparam logic [15:0] BYPASS_MAX = 16'd1;

   // Split a ratio into {high length, low length}. The short half goes high
   // unless the caller asks for the long half high on odd ratios.
   function automatic logic [31:0] phase_len(input logic [15:0] ratio,
                                             input logic        odd_high_long);
      logic [15:0] loHalf;
      logic [15:0] hiHalf;
      loHalf = ratio >> 1;
      hiHalf = ratio - loHalf;
      if (odd_high_long && ratio[0]) begin
         return {hiHalf, loHalf};
      end
      return {loHalf, hiHalf};
   endfunction

endpackage

// File: rtl/clk_gate_cell.sv
// Latch-based integrated clock gate used only on the bypass path.
// Kept as its own module so a library ICG cell can be dropped in.
module clk_gate_cell (
   input  logic i_clk,
   input  logic i_en,
   output logic o_gclk
);

   logic r_enLatch;

   // Enable is transparent while the clock is low, so it is frozen for the whole high phase
   always_latch begin
      if (!i_clk) begin
         r_enLatch <= i_en;
      end
   end

   assign o_gclk = i_clk & r_enLatch;

endmodule

// File: rtl/prog_clock_divider.sv
// Programmable integer clock divider with glitch-free ratio changes.
// Ratio and enable changes land only on output-period boundaries; ratios
// 0 and 1 pass the reference clock through a clock gate instead.
module prog_clock_divider #(
   parameter int DIV_WIDTH     = 8,
   parameter bit ODD_HIGH_LONG = 1'b0,
   parameter int RST_RATIO     = 2
) (
   input  logic                 i_ref_clk,
   input  logic                 i_rst_n,
   input  logic                 i_clk_en,
   input  logic [DIV_WIDTH-1:0] i_div_ratio,
   input  logic                 i_ratio_load,
   output logic                 o_div_clk,
   output logic                 o_div_pulse,
   output logic                 o_ratio_busy,
   output logic [DIV_WIDTH-1:0] o_active_ratio
);

   import clk_div_pkg::*;

   div_state_e           r_state;
   logic [DIV_WIDTH-1:0] r_count;
   logic [DIV_WIDTH-1:0] r_pendingRatio;
   logic [DIV_WIDTH-1:0] r_activeRatio;
   logic                 r_busy;
   logic                 r_divClk;
   logic                 r_divPulse;

   logic [31:0]          w_phase;
   logic [DIV_WIDTH-1:0] w_highLast;
   logic [DIV_WIDTH-1:0] w_lowLast;
   logic [DIV_WIDTH-1:0] w_nextRatio;
   logic                 w_nextBypass;
   logic                 w_commit;
   logic                 w_gateEn;
   logic                 w_gatedClk;

   assign w_phase    = phase_len(16'(r_activeRatio), ODD_HIGH_LONG);
   assign w_highLast = DIV_WIDTH'(w_phase[31:16] - 16'd1);
   assign w_lowLast  = DIV_WIDTH'(w_phase[15:0] - 16'd1);

   // A pending ratio may only become active in IDLE, in BYPASS, or on the last LOW cycle
   always_comb begin
      w_commit = 1'b0;
      case (r_state)
         IDLE:    w_commit = r_busy;
         BYPASS:  w_commit = r_busy;
         LOW:     w_commit = r_busy && (r_count == w_lowLast);
         default: w_commit = 1'b0;
      endcase
   end

   assign w_nextRatio  = w_commit ? r_pendingRatio : r_activeRatio;
   assign w_nextBypass = (16'(w_nextRatio) <= BYPASS_MAX);

   // Capture requested ratios; the latest load wins and busy holds until a commit with no new load
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pendingRatio <= DIV_WIDTH'(RST_RATIO);
         r_activeRatio  <= DIV_WIDTH'(RST_RATIO);
         r_busy         <= 1'b0;
      end else begin
         if (w_commit) begin
            r_activeRatio <= r_pendingRatio;
         end
         if (i_ratio_load) begin
            r_pendingRatio <= i_div_ratio;
            r_busy         <= 1'b1;
         end else if (w_commit) begin
            r_busy <= 1'b0;
         end
      end
   end

   // Divider FSM: phase counting, boundary decisions and the registered output/strobe one cycle behind the state
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_divClk   <= 1'b0;
         r_divPulse <= 1'b0;
      end else begin
         r_divClk   <= (r_state == HIGH);
         r_divPulse <= ((r_state == HIGH) && (r_count == '0)) || (r_state == BYPASS);
         case (r_state)
            IDLE: begin
               r_count <= '0;
               if (i_clk_en) begin
                  r_state <= w_nextBypass ? BYPASS : HIGH;
               end
            end
            HIGH: begin
               if (r_count == w_highLast) begin
                  r_state <= LOW;
                  r_count <= '0;
               end else begin
                  r_count <= r_count + DIV_WIDTH'(1);
               end
            end
            LOW: begin
               if (r_count == w_lowLast) begin
                  r_count <= '0;
                  if (!i_clk_en) begin
                     r_state <= IDLE;
                  end else if (w_nextBypass) begin
                     r_state <= BYPASS;
                  end else begin
                     r_state <= HIGH;
                  end
               end else begin
                  r_count <= r_count + DIV_WIDTH'(1);
               end
            end
            BYPASS: begin
               r_count <= '0;
               if (!i_clk_en) begin
                  r_state <= IDLE;
               end else if (!w_nextBypass) begin
                  r_state <= HIGH;
               end
            end
            default: begin
               r_state <= IDLE;
               r_count <= '0;
            end
         endcase
      end
   end

   assign w_gateEn = (r_state == BYPASS);

   clk_gate_cell u_bypassGate (
      .i_clk  (i_ref_clk),
      .i_en   (w_gateEn),
      .o_gclk (w_gatedClk)
   );

   assign o_div_clk      = r_divClk | (w_gatedClk & i_rst_n);
   assign o_div_pulse    = r_divPulse;
   assign o_ratio_busy   = r_busy;
   assign o_active_ratio = r_activeRatio;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider. Two instances share stimulus:
// instance A splits odd ratios low-long, instance B high-long.
module tb_prog_clock_divider;

   logic       refClk    = 1'b0;
   logic       rstN      = 1'b1;
   logic       clkEn     = 1'b0;
   logic [7:0] divRatio  = 8'd0;
   logic       ratioLoad = 1'b0;

   logic       divClkA, pulseA, busyA;
   logic       divClkB, pulseB, busyB;
   logic [7:0] activeA, activeB;

   int testsRun    = 0;
   int testsFailed = 0;

   prog_clock_divider #(
      .DIV_WIDTH     (8),
      .ODD_HIGH_LONG (1'b0),
      .RST_RATIO     (2)
   ) dutA (
      .i_ref_clk      (refClk),
      .i_rst_n        (rstN),
      .i_clk_en       (clkEn),
      .i_div_ratio    (divRatio),
      .i_ratio_load   (ratioLoad),
      .o_div_clk      (divClkA),
      .o_div_pulse    (pulseA),
      .o_ratio_busy   (busyA),
      .o_active_ratio (activeA)
   );

   prog_clock_divider #(
      .DIV_WIDTH     (8),
      .ODD_HIGH_LONG (1'b1),
      .RST_RATIO     (2)
   ) dutB (
      .i_ref_clk      (refClk),
      .i_rst_n        (rstN),
      .i_clk_en       (clkEn),
      .i_div_ratio    (divRatio),
      .i_ratio_load   (ratioLoad),
      .o_div_clk      (divClkB),
      .o_div_pulse    (pulseB),
      .o_ratio_busy   (busyB),
      .o_active_ratio (activeB)
   );

   // Reference clock, 10 time units per period
   always #5 refClk = ~refClk;

   // Advance to just after the next rising edge, where outputs are sampled and inputs changed
   task automatic tick();
      @(posedge refClk);
      #1;
   endtask

   // Hold reset for two edges with everything idle, then release
   task automatic doReset();
      rstN      = 1'b0;
      clkEn     = 1'b0;
      ratioLoad = 1'b0;
      divRatio  = 8'd0;
      repeat (2) @(posedge refClk);
      #1;
      rstN = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      rstN = 1'b0;
      #1;
      testsRun++;
      if (divClkA !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_divclk: got %b expected 0", divClkA); end
      testsRun++;
      if (pulseA !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_pulse: got %b expected 0", pulseA); end
      testsRun++;
      if (busyA !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busyA); end
      testsRun++;
      if (activeA !== 8'd2) begin testsFailed++; $display("[TB] FAIL reset_active: got %0d expected 2", activeA); end
      testsRun++;
      if (divClkB !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_divclk_b: got %b expected 0", divClkB); end
      testsRun++;
      if (activeB !== 8'd2) begin testsFailed++; $display("[TB] FAIL reset_active_b: got %0d expected 2", activeB); end
      repeat (2) @(posedge refClk);
      #1;
      rstN = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         testsRun++;
         if (divClkA !== 1'b0 || pulseA !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL idle_disabled cycle %0d: got clk=%b pulse=%b expected 0/0", k, divClkA, pulseA);
         end
      end
   endtask

   task automatic test_ratio2();
      logic expBit;
      doReset();
      clkEn = 1'b1;
      tick();
      testsRun++;
      if (divClkA !== 1'b0) begin testsFailed++; $display("[TB] FAIL ratio2_enable_edge: got %b expected 0", divClkA); end
      for (int k = 1; k <= 8; k++) begin
         tick();
         expBit = (k % 2 == 1);
         testsRun++;
         if (divClkA !== expBit) begin testsFailed++; $display("[TB] FAIL ratio2_clk cycle %0d: got %b expected %b", k, divClkA, expBit); end
         testsRun++;
         if (pulseA !== expBit) begin testsFailed++; $display("[TB] FAIL ratio2_pulse cycle %0d: got %b expected %b", k, pulseA, expBit); end
      end
      testsRun++;
      if (activeA !== 8'd2) begin testsFailed++; $display("[TB] FAIL ratio2_active: got %0d expected 2", activeA); end
   endtask

   task automatic test_odd_ratio();
      logic expA, expB, expP;
      doReset();
      clkEn = 1'b1;
      tick();
      ratioLoad = 1'b1;
      divRatio  = 8'd5;
      tick();
      ratioLoad = 1'b0;
      testsRun++;
      if (busyA !== 1'b1) begin testsFailed++; $display("[TB] FAIL odd_busy_before_boundary: got %b expected 1", busyA); end
      testsRun++;
      if (activeA !== 8'd2) begin testsFailed++; $display("[TB] FAIL odd_active_before_boundary: got %0d expected 2", activeA); end
      tick();
      testsRun++;
      if (busyA !== 1'b0) begin testsFailed++; $display("[TB] FAIL odd_busy_after_commit: got %b expected 0", busyA); end
      testsRun++;
      if (activeA !== 8'd5) begin testsFailed++; $display("[TB] FAIL odd_active_after_commit: got %0d expected 5", activeA); end
      testsRun++;
      if (activeB !== 8'd5 || busyB !== 1'b0) begin testsFailed++; $display("[TB] FAIL odd_commit_b: got active=%0d busy=%b expected 5/0", activeB, busyB); end
      for (int j = 0; j < 10; j++) begin
         tick();
         expA = ((j % 5) < 2);
         expB = ((j % 5) < 3);
         expP = ((j % 5) == 0);
         testsRun++;
         if (divClkA !== expA) begin testsFailed++; $display("[TB] FAIL odd_low_long_clk cycle %0d: got %b expected %b", j, divClkA, expA); end
         testsRun++;
         if (divClkB !== expB) begin testsFailed++; $display("[TB] FAIL odd_high_long_clk cycle %0d: got %b expected %b", j, divClkB, expB); end
         testsRun++;
         if (pulseA !== expP || pulseB !== expP) begin
            testsFailed++;
            $display("[TB] FAIL odd_pulse cycle %0d: got a=%b b=%b expected %b", j, pulseA, pulseB, expP);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [13:0] expClk;
      logic [13:0] expPulse;
      logic [7:0]  expAct;
      logic        expBusy;
      expClk   = 14'b11100011001100;
      expPulse = 14'b10000010001000;
      doReset();
      ratioLoad = 1'b1;
      divRatio  = 8'd6;
      tick();
      ratioLoad = 1'b0;
      testsRun++;
      if (busyA !== 1'b1) begin testsFailed++; $display("[TB] FAIL idle_load_busy: got %b expected 1", busyA); end
      tick();
      testsRun++;
      if (busyA !== 1'b0 || activeA !== 8'd6) begin
         testsFailed++;
         $display("[TB] FAIL idle_commit_disabled: got busy=%b active=%0d expected 0/6", busyA, activeA);
      end
      clkEn = 1'b1;
      tick();
      for (int k = 1; k <= 14; k++) begin
         if (k == 1) begin
            ratioLoad = 1'b1;
            divRatio  = 8'd7;
         end else if (k == 2) begin
            divRatio  = 8'd4;
         end else if (k == 3) begin
            ratioLoad = 1'b0;
         end
         tick();
         expAct  = (k <= 5) ? 8'd6 : 8'd4;
         expBusy = (k <= 5);
         testsRun++;
         if (divClkA !== expClk[14-k]) begin testsFailed++; $display("[TB] FAIL b2b_clk cycle %0d: got %b expected %b", k, divClkA, expClk[14-k]); end
         testsRun++;
         if (pulseA !== expPulse[14-k]) begin testsFailed++; $display("[TB] FAIL b2b_pulse cycle %0d: got %b expected %b", k, pulseA, expPulse[14-k]); end
         testsRun++;
         if (activeA !== expAct) begin testsFailed++; $display("[TB] FAIL b2b_active cycle %0d: got %0d expected %0d", k, activeA, expAct); end
         testsRun++;
         if (busyA !== expBusy) begin testsFailed++; $display("[TB] FAIL b2b_busy cycle %0d: got %b expected %b", k, busyA, expBusy); end
      end
   endtask

   task automatic test_disable();
      logic expBit;
      doReset();
      ratioLoad = 1'b1;
      divRatio  = 8'd6;
      tick();
      ratioLoad = 1'b0;
      tick();
      clkEn = 1'b1;
      tick();
      tick();
      testsRun++;
      if (divClkA !== 1'b1 || pulseA !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL disable_first_high: got clk=%b pulse=%b expected 1/1", divClkA, pulseA);
      end
      clkEn = 1'b0;
      for (int k = 2; k <= 11; k++) begin
         tick();
         expBit = (k <= 3);
         testsRun++;
         if (divClkA !== expBit) begin testsFailed++; $display("[TB] FAIL disable_clk cycle %0d: got %b expected %b", k, divClkA, expBit); end
         testsRun++;
         if (pulseA !== 1'b0) begin testsFailed++; $display("[TB] FAIL disable_pulse cycle %0d: got %b expected 0", k, pulseA); end
      end
   endtask

   task automatic test_bypass();
      logic [5:0] expDiv;
      expDiv = 6'b100100;
      doReset();
      clkEn = 1'b1;
      tick();
      ratioLoad = 1'b1;
      divRatio  = 8'd1;
      tick();
      divRatio  = 8'd0;
      tick();
      ratioLoad = 1'b0;
      testsRun++;
      if (activeA !== 8'd1 || busyA !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL bypass_commit_with_load: got active=%0d busy=%b expected 1/1", activeA, busyA);
      end
      testsRun++;
      if (divClkA !== 1'b0) begin testsFailed++; $display("[TB] FAIL bypass_entry_high: got %b expected 0", divClkA); end
      #5;
      testsRun++;
      if (divClkA !== 1'b0) begin testsFailed++; $display("[TB] FAIL bypass_entry_low: got %b expected 0", divClkA); end
      for (int k = 3; k <= 7; k++) begin
         if (k == 6) begin
            ratioLoad = 1'b1;
            divRatio  = 8'd3;
         end else if (k == 7) begin
            ratioLoad = 1'b0;
         end
         tick();
         testsRun++;
         if (divClkA !== 1'b1 || pulseA !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL bypass_high cycle %0d: got clk=%b pulse=%b expected 1/1", k, divClkA, pulseA);
         end
         if (k == 3) begin
            testsRun++;
            if (activeA !== 8'd0 || busyA !== 1'b0) begin
               testsFailed++;
               $display("[TB] FAIL bypass_ratio0: got active=%0d busy=%b expected 0/0", activeA, busyA);
            end
         end
         if (k == 7) begin
            testsRun++;
            if (activeA !== 8'd3 || busyA !== 1'b0) begin
               testsFailed++;
               $display("[TB] FAIL bypass_exit_commit: got active=%0d busy=%b expected 3/0", activeA, busyA);
            end
         end
         #5;
         testsRun++;
         if (divClkA !== 1'b0) begin testsFailed++; $display("[TB] FAIL bypass_low cycle %0d: got %b expected 0", k, divClkA); end
      end
      for (int k = 8; k <= 13; k++) begin
         tick();
         testsRun++;
         if (divClkA !== expDiv[13-k] || pulseA !== expDiv[13-k]) begin
            testsFailed++;
            $display("[TB] FAIL resume3_high cycle %0d: got clk=%b pulse=%b expected %b", k, divClkA, pulseA, expDiv[13-k]);
         end
         #5;
         testsRun++;
         if (divClkA !== expDiv[13-k]) begin testsFailed++; $display("[TB] FAIL resume3_low cycle %0d: got %b expected %b", k, divClkA, expDiv[13-k]); end
      end
   endtask

   task automatic test_reset_midperiod();
      logic expBit;
      doReset();
      ratioLoad = 1'b1;
      divRatio  = 8'd200;
      tick();
      ratioLoad = 1'b0;
      tick();
      clkEn = 1'b1;
      tick();
      repeat (110) tick();
      ratioLoad = 1'b1;
      divRatio  = 8'd9;
      tick();
      ratioLoad = 1'b0;
      testsRun++;
      if (activeA !== 8'd200 || busyA !== 1'b1 || divClkA !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL midlow_state: got active=%0d busy=%b clk=%b expected 200/1/0", activeA, busyA, divClkA);
      end
      #2;
      rstN = 1'b0;
      #1;
      testsRun++;
      if (activeA !== 8'd2) begin testsFailed++; $display("[TB] FAIL async_reset_active: got %0d expected 2", activeA); end
      testsRun++;
      if (busyA !== 1'b0) begin testsFailed++; $display("[TB] FAIL async_reset_busy: got %b expected 0", busyA); end
      testsRun++;
      if (divClkA !== 1'b0 || pulseA !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL async_reset_outputs: got clk=%b pulse=%b expected 0/0", divClkA, pulseA);
      end
      #1;
      rstN = 1'b1;
      tick();
      testsRun++;
      if (divClkA !== 1'b0) begin testsFailed++; $display("[TB] FAIL resume_enable_edge: got %b expected 0", divClkA); end
      for (int k = 1; k <= 6; k++) begin
         tick();
         expBit = (k % 2 == 1);
         testsRun++;
         if (divClkA !== expBit || pulseA !== expBit) begin
            testsFailed++;
            $display("[TB] FAIL resume_ratio2 cycle %0d: got clk=%b pulse=%b expected %b", k, divClkA, pulseA, expBit);
         end
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_ratio2();
      test_odd_ratio();
      test_back_to_back();
      test_disable();
      test_bypass();
      test_reset_midperiod();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/prog_clock_divider.md
# prog_clock_divider

Parametrised integer clock divider, successor to the fixed 8-bit divider: it divides `i_ref_clk` by a run-time ratio of configurable width. Ratio changes and enable changes take effect only at output-period boundaries, so `o_div_clk` never produces runt pulses. Ratio 0/1 selects a gated bypass. A per-period strobe in the `i_ref_clk` domain lets downstream logic (UART prescalers, samplers) use the block as a clock-enable source.

## Interface
- `DIV_WIDTH`, 8: width of the ratio and the internal counters; legal 2..16.
- `ODD_HIGH_LONG`, 0: for odd ratios, 0 = low phase one cycle longer, 1 = high phase one cycle longer.
- `RST_RATIO`, 2: active ratio after reset.
- `i_ref_clk` in 1: reference clock. This is the only clock in the block.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_clk_en` in 1: divider enable.
- `i_div_ratio` in DIV_WIDTH: requested ratio, sampled only on `i_ratio_load`.
- `i_ratio_load` in 1: single-cycle strobe that captures `i_div_ratio` into the pending register.
- `o_div_clk` out 1: divided clock.
- `o_div_pulse` out 1: one `i_ref_clk` cycle high on the cycle `o_div_clk` rises; also asserted every enabled cycle in bypass.
- `o_ratio_busy` out 1: a pending ratio is not yet committed.
- `o_active_ratio` out DIV_WIDTH: the ratio currently in effect.

## Operation
- Phase lengths for N≥2:
  - H = floor(N/2) and L = N−H, or the two values swapped when `ODD_HIGH_LONG`=1 and N is odd.
  - Even N gives exactly 50% duty.
- States:
  - IDLE: output low, counter 0.
  - HIGH: counter runs 0..H−1.
  - LOW: counter runs 0..L−1.
  - BYPASS.
- IDLE transitions, sampled at the rising edge where `i_clk_en`=1:
  - Any pending ratio is committed first.
  - If the active ratio is ≥2, go to HIGH.
  - If the active ratio is ≤1, go to BYPASS.
- HIGH → LOW at count H−1.
- LOW at count L−1 is the period boundary:
  - Commit any pending ratio.
  - If `i_clk_en`=0, go to IDLE.
  - Else if the new ratio is ≤1, go to BYPASS.
  - Else go to HIGH.
- BYPASS, evaluated on every edge:
  - Commit any pending ratio.
  - If `i_clk_en`=0, go to IDLE.
  - If the ratio is now ≥2, go to HIGH.
  - In BYPASS, `o_div_clk` = `i_ref_clk` gated by an ICG-style enable. The gate enable is transparent while `i_ref_clk` is low, which makes the output glitch-free.
- Disable in HIGH/LOW: the current period always completes; no truncated phases.
- Ratio load:
  - `i_ratio_load` sets pending and `o_ratio_busy`.
  - A load while busy overwrites pending; the last load wins and `o_ratio_busy` stays high.
  - A load in the same cycle as a commit: the new value is pending and busy remains 1.
  - In IDLE, the commit happens on the next edge even when disabled, and busy clears.
- `o_active_ratio` updates on the commit edge.

## Timing
- Reset values: `o_div_clk`=0, `o_div_pulse`=0, `o_ratio_busy`=0, `o_active_ratio`=`RST_RATIO`. State is IDLE and the counter is 0.
- In divided mode, `o_div_clk` is registered: it rises one edge after the enable/boundary edge. The first rising edge comes one cycle after `i_clk_en` is sampled high.
- Period is exactly N `i_ref_clk` cycles. `o_div_pulse` is coincident with the cycle `o_div_clk` is high for the first time in each period.
- Reset asserted mid-period forces the reset values immediately, with no completion.
- The counter never wraps past H−1/L−1; comparisons use DIV_WIDTH bits.
- A ratio of 2^DIV_WIDTH−1 is legal.

## Structure
- Shared package `clk_div_pkg` holds:
  - state enum `div_state_e` (IDLE, HIGH, LOW, BYPASS);
  - function `phase_len(ratio, odd_high_long)`, which returns {H, L};
  - constant `BYPASS_MAX`=1.
- One sub-module, `clk_gate_cell`: a latch-based ICG used only for the bypass path, so it can be swapped for a library cell.

## Test plan
- After reset, set `i_clk_en`=1 with the default ratio 2 → period 2, 50% duty, `o_div_pulse` every 2 cycles, `o_active_ratio`=2.
- Load 5 with `ODD_HIGH_LONG`=0 mid-period:
  - `o_ratio_busy`=1 until the boundary.
  - Then 2 high / 3 low repeating; busy clears on the commit edge.
  - A second run with `ODD_HIGH_LONG`=1 → 3 high / 2 low.
- Load 7, then load 4 before the boundary → 4 is committed and 7 is never observed; each period is exactly 4 or the old ratio, with no runt pulse.
- Set `i_clk_en`=0 while ratio 6 is in HIGH count 1 → the full 3 high + 3 low period completes, then the output stays low, state IDLE.
- Load 1, then load 0, then load 3 → bypass follows `i_ref_clk` with no glitch at entry or exit, and `o_div_pulse`=1 each bypass cycle. Ratio 3 resumes on the first edge after commit.
- Assert `i_rst_n` low mid-LOW with ratio 200 (`DIV_WIDTH`=8) → all outputs go to their reset values asynchronously. After release with `i_clk_en`=1, division resumes at ratio 2.
